// File: rtl/mem_stage_if.sv
// Bus between ex_stage and mem_stage: request fields, writeback, redirect and condition.
// mem_trap exists only when MEM_MISALIGN_TRAP_EN is defined.
interface mem_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 6
);
  logic              in_valid;
  logic              in_ready;
  logic              is_load;
  logic              is_store;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] newPC;
  logic [3:0]        branch;
  logic [RD_W-1:0]   rd;
  logic [3:0]        cond_in;
  logic              set_cond;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic [RD_W-1:0]   wb_rd;
  logic              pc_sel;
  logic [DATA_W-1:0] pc_target;
  logic [3:0]        alu_cond;
`ifdef MEM_MISALIGN_TRAP_EN
  logic              mem_trap;
`endif

  // Stage side.
  modport slave (
    input  in_valid, is_load, is_store, alu_result, store_data, newPC,
           branch, rd, cond_in, set_cond,
    output in_ready, wb_valid, wb_data, wb_rd, pc_sel, pc_target, alu_cond
`ifdef MEM_MISALIGN_TRAP_EN
    , output mem_trap
`endif
  );

  // ex_stage / writeback side.
  modport master (
    output in_valid, is_load, is_store, alu_result, store_data, newPC,
           branch, rd, cond_in, set_cond,
    input  in_ready, wb_valid, wb_data, wb_rd, pc_sel, pc_target, alu_cond
`ifdef MEM_MISALIGN_TRAP_EN
    , input mem_trap
`endif
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: registers ex_stage results, runs MEM_LAT-cycle loads/stores on a word RAM,
// resolves branches and holds the condition register. Optional: MEM_MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned RD_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_load_q, op_load_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] st_data_q, st_data_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              in_ready_q, in_ready_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic              pc_sel_q, pc_sel_d;
  logic [DATA_W-1:0] pc_target_q, pc_target_d;
  logic [3:0]        alu_cond_q, alu_cond_d;
  logic              mem_trap_q, mem_trap_d;
  logic              mem_we_c;
  logic              xfer_c;
  logic              is_mem_c;
  logic              misalign_c;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign xfer_c   = bus.in_valid && in_ready_q;
  assign is_mem_c = bus.is_load || bus.is_store;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_c = (bus.alu_result[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_load_d   = op_load_q;
    idx_d       = idx_q;
    st_data_d   = st_data_q;
    rd_d        = rd_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    pc_sel_d    = 1'b0;
    pc_target_d = pc_target_q;
    alu_cond_d  = alu_cond_q;
    mem_trap_d  = 1'b0;
    mem_we_c    = 1'b0;

    case (state_q)
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d    = DONE;
          mem_we_c   = !op_load_q;
          wb_valid_d = op_load_q;
          wb_data_d  = mem_q[idx_q];
          wb_rd_d    = rd_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A transfer can only happen in IDLE or DONE; it overrides DONE->IDLE.
    if (xfer_c) begin
      if (bus.branch != 4'd0) begin
        pc_sel_d    = 1'b1;
        pc_target_d = bus.newPC;
      end
      if (bus.set_cond) alu_cond_d = bus.cond_in;
      if (is_mem_c && misalign_c) begin
        state_d    = IDLE;
        mem_trap_d = 1'b1;
      end else if (is_mem_c) begin
        state_d   = ACCESS;
        cnt_d     = CNT_W'(MEM_LAT - 1);
        op_load_d = bus.is_load;
        idx_d     = bus.alu_result[ADDR_W+1:2];
        st_data_d = bus.store_data;
        rd_d      = bus.rd;
      end else begin
        state_d    = IDLE;
        wb_valid_d = 1'b1;
        wb_data_d  = bus.alu_result;
        wb_rd_d    = bus.rd;
      end
    end

    in_ready_d = (state_d != ACCESS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_load_q   <= 1'b0;
      idx_q       <= '0;
      st_data_q   <= '0;
      rd_q        <= '0;
      in_ready_q  <= 1'b1;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      pc_sel_q    <= 1'b0;
      pc_target_q <= '0;
      alu_cond_q  <= 4'd0;
      mem_trap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_load_q   <= op_load_d;
      idx_q       <= idx_d;
      st_data_q   <= st_data_d;
      rd_q        <= rd_d;
      in_ready_q  <= in_ready_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      pc_sel_q    <= pc_sel_d;
      pc_target_q <= pc_target_d;
      alu_cond_q  <= alu_cond_d;
      mem_trap_q  <= mem_trap_d;
    end
  end

  // RAM keeps its contents across reset; reset blocks an in-flight store.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem_q[idx_q] <= st_data_q;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.pc_sel    = pc_sel_q;
  assign bus.pc_target = pc_target_q;
  assign bus.alu_cond  = alu_cond_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign bus.mem_trap  = mem_trap_q;
`else
  logic unused_trap_c;
  assign unused_trap_c = mem_trap_q;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table of single ops plus hand sequences for
// back-to-back, transfer-in-DONE, reset mid-access and misaligned access.
module tb_mem_stage;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned RD_W    = 6;
  localparam int          NVEC    = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

  mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] npc;
    logic [3:0]  br;
    logic [5:0]  rd;
    logic [3:0]  cond;
    logic        setc;
    logic [3:0]  wb_cyc;   // cycle after transfer with wb_valid, 0 = none
    logic [31:0] wbd;
    logic [3:0]  exp_cond;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.is_load = 1'b0; bus.is_store = 1'b0;
    bus.alu_result = '0; bus.store_data = '0; bus.newPC = '0;
    bus.branch = '0; bus.rd = '0; bus.cond_in = '0; bus.set_cond = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = 1'b1; bus.is_load = v.ld; bus.is_store = v.st;
    bus.alu_result = v.alu; bus.store_data = v.sd; bus.newPC = v.npc;
    bus.branch = v.br; bus.rd = v.rd; bus.cond_in = v.cond; bus.set_cond = v.setc;
  endtask

  // Wait (bounded) for in_ready at a falling edge.
  task automatic wait_ready(input string nm);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({nm, "_ready_timeout"}, 32'(bus.in_ready), 32'd1);
  endtask

  function automatic vec_t mk(input logic ld, input logic st, input logic [31:0] alu,
                              input logic [31:0] sd, input logic [31:0] npc,
                              input logic [3:0] br, input logic [5:0] rd,
                              input logic [3:0] cond, input logic setc,
                              input logic [3:0] wb_cyc, input logic [31:0] wbd,
                              input logic [3:0] exp_cond);
    vec_t v;
    v.ld = ld; v.st = st; v.alu = alu; v.sd = sd; v.npc = npc; v.br = br; v.rd = rd;
    v.cond = cond; v.setc = setc; v.wb_cyc = wb_cyc; v.wbd = wbd; v.exp_cond = exp_cond;
    return v;
  endfunction

  // Apply one op from IDLE and observe MEM_LAT+2 cycles after the transfer edge.
  task automatic run_vec(input vec_t v, input string nm);
    int          wb_cnt = 0, wb_cyc = 0, pc_cnt = 0, rdy_low = 0;
    logic [31:0] wbd = '0, pct = '0;
    logic [5:0]  wbr = '0;
    wait_ready(nm);
    drive(v);
    for (int c = 1; c <= int'(MEM_LAT) + 2; c++) begin
      @(negedge clk);
      if (c == 1) idle_inputs();
      if (bus.wb_valid) begin wb_cnt++; wb_cyc = c; wbd = bus.wb_data; wbr = bus.wb_rd; end
      if (bus.pc_sel) begin pc_cnt++; pct = bus.pc_target; end
      if (!bus.in_ready) rdy_low++;
    end
    chk({nm, "_wb_count"}, 32'(wb_cnt), (v.wb_cyc != 0) ? 32'd1 : 32'd0);
    if (v.wb_cyc != 0) begin
      chk({nm, "_wb_cycle"}, 32'(wb_cyc), 32'(v.wb_cyc));
      chk({nm, "_wb_data"}, wbd, v.wbd);
      chk({nm, "_wb_rd"}, 32'(wbr), 32'(v.rd));
    end
    chk({nm, "_pc_sel_count"}, 32'(pc_cnt), (v.br != 0) ? 32'd1 : 32'd0);
    if (v.br != 0) chk({nm, "_pc_target"}, pct, v.npc);
    chk({nm, "_ready_low"}, 32'(rdy_low), (v.ld || v.st) ? 32'(MEM_LAT) : 32'd0);
    chk({nm, "_alu_cond"}, 32'(bus.alu_cond), 32'(v.exp_cond));
  endtask

  initial begin
    vec_t v;
    int   trap_cnt, wb_cnt, rdy_low;
    //           ld    st    alu           sd            npc       br     rd     cond   setc  cyc   wbd           cond
    vecs[0]  = mk(1'b0, 1'b0, 32'h1234,     32'h0,        32'h0,    4'h0, 6'd5, 4'h0, 1'b0, 4'd1, 32'h1234,     4'h0);
    vecs[1]  = mk(1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 32'h0,    4'h0, 6'd1, 4'h0, 1'b0, 4'd0, 32'h0,        4'h0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h10,       32'h0,        32'h0,    4'h0, 6'd7, 4'h0, 1'b0, 4'd3, 32'hDEADBEEF, 4'h0);
    vecs[3]  = mk(1'b0, 1'b0, 32'h99,       32'h0,        32'h40,   4'h1, 6'd2, 4'h0, 1'b0, 4'd1, 32'h99,       4'h0);
    vecs[4]  = mk(1'b0, 1'b0, 32'h5,        32'h0,        32'h0,    4'h0, 6'd3, 4'hA, 1'b1, 4'd1, 32'h5,        4'hA);
    vecs[5]  = mk(1'b0, 1'b0, 32'h6,        32'h0,        32'h0,    4'h0, 6'd3, 4'h3, 1'b0, 4'd1, 32'h6,        4'hA);
    vecs[6]  = mk(1'b0, 1'b1, 32'h3FC,      32'h0BADF00D, 32'h0,    4'h0, 6'd0, 4'h0, 1'b0, 4'd0, 32'h0,        4'hA);
    vecs[7]  = mk(1'b1, 1'b0, 32'h7FC,      32'h0,        32'h0,    4'h0, 6'd9, 4'h0, 1'b0, 4'd3, 32'h0BADF00D, 4'hA);
    vecs[8]  = mk(1'b1, 1'b0, 32'h10,       32'h0,        32'h80,   4'h8, 6'd3, 4'h5, 1'b1, 4'd3, 32'hDEADBEEF, 4'h5);
    vecs[9]  = mk(1'b1, 1'b1, 32'h10,       32'h55,       32'h0,    4'h0, 6'd4, 4'h0, 1'b0, 4'd3, 32'hDEADBEEF, 4'h5);
    vecs[10] = mk(1'b1, 1'b0, 32'h10,       32'h0,        32'h0,    4'h0, 6'd6, 4'h0, 1'b0, 4'd3, 32'hDEADBEEF, 4'h5);

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("reset_pc_sel", 32'(bus.pc_sel), 32'd0);
    chk("reset_alu_cond", 32'(bus.alu_cond), 32'd0);
    chk("reset_wb_data", bus.wb_data, 32'd0);
    chk("reset_pc_target", bus.pc_target, 32'd0);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back ALU transfers.
    wait_ready("b2b");
    drive(mk(1'b0, 1'b0, 32'h11, 32'h0, 32'h0, 4'h0, 6'd1, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0));
    @(negedge clk);
    chk("b2b_first_valid", 32'(bus.wb_valid), 32'd1);
    chk("b2b_first_data", bus.wb_data, 32'h11);
    chk("b2b_ready", 32'(bus.in_ready), 32'd1);
    drive(mk(1'b0, 1'b0, 32'h22, 32'h0, 32'h0, 4'h0, 6'd2, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0));
    @(negedge clk);
    idle_inputs();
    chk("b2b_second_valid", 32'(bus.wb_valid), 32'd1);
    chk("b2b_second_data", bus.wb_data, 32'h22);
    chk("b2b_second_rd", 32'(bus.wb_rd), 32'd2);
    @(negedge clk);
    chk("b2b_strobe_ends", 32'(bus.wb_valid), 32'd0);

    // Transfer accepted in DONE while the load completes.
    drive(mk(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 4'h0, 6'd7, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0));
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("done_load_valid", 32'(bus.wb_valid), 32'd1);
    chk("done_load_data", bus.wb_data, 32'hDEADBEEF);
    chk("done_load_rd", 32'(bus.wb_rd), 32'd7);
    chk("done_ready", 32'(bus.in_ready), 32'd1);
    drive(mk(1'b0, 1'b0, 32'h77, 32'h0, 32'h0, 4'h0, 6'd8, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0));
    @(negedge clk);
    idle_inputs();
    chk("done_alu_valid", 32'(bus.wb_valid), 32'd1);
    chk("done_alu_data", bus.wb_data, 32'h77);
    chk("done_alu_rd", 32'(bus.wb_rd), 32'd8);

    // Reset in the middle of a store access aborts the write.
    @(negedge clk);
    drive(mk(1'b0, 1'b1, 32'h10, 32'h12345678, 32'h0, 4'h0, 6'd1, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0));
    @(negedge clk);
    idle_inputs();
    chk("abort_busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", 32'(bus.in_ready), 32'd1);
    wb_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.wb_valid) wb_cnt++;
    end
    chk("abort_no_wb", 32'(wb_cnt), 32'd0);
    run_vec(mk(1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 4'h0, 6'd2, 4'h0, 1'b0, 4'd3, 32'hDEADBEEF, 4'h0),
            "abort_reload");

    // Misaligned access.
`ifdef MEM_MISALIGN_TRAP_EN
    wait_ready("trap");
    drive(mk(1'b1, 1'b0, 32'h11, 32'h0, 32'h0, 4'h0, 6'd3, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0));
    trap_cnt = 0; wb_cnt = 0; rdy_low = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        idle_inputs();
        chk("trap_next_cycle", 32'(bus.mem_trap), 32'd1);
      end
      if (bus.mem_trap) trap_cnt++;
      if (bus.wb_valid) wb_cnt++;
      if (!bus.in_ready) rdy_low++;
    end
    chk("trap_count", 32'(trap_cnt), 32'd1);
    chk("trap_no_wb", 32'(wb_cnt), 32'd0);
    chk("trap_stays_idle", 32'(rdy_low), 32'd0);
`else
    trap_cnt = 0; rdy_low = 0;
    run_vec(mk(1'b1, 1'b0, 32'h11, 32'h0, 32'h0, 4'h0, 6'd3, 4'h0, 1'b0, 4'd3, 32'hDEADBEEF, 4'h0),
            "misalign_ignored");
`endif
    v = vecs[0];
    run_vec(v, "final_alu");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
